// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU function codes,
// FSM state encoding and the round-robin grant helper.
package alu_arbiter_pkg;

  localparam logic [2:0] FUNC_ADD    = 3'd0;
  localparam logic [2:0] FUNC_SUB    = 3'd1;
  localparam logic [2:0] FUNC_AND    = 3'd2;
  localparam logic [2:0] FUNC_OR     = 3'd3;
  localparam logic [2:0] FUNC_NOR    = 3'd4;
  localparam logic [2:0] FUNC_XOR    = 3'd5;
  localparam logic [2:0] FUNC_SLTU   = 3'd6;
  localparam logic [2:0] FUNC_PASS_B = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Under contention the requester that did not win last time gets the grant.
  function automatic logic pick_grant(input logic valid0, input logic valid1,
                                      input logic last_grant);
    if (valid0 && valid1) return ~last_grant;
    return valid1;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by both requesters; results wrap modulo
// 2^SIZE and the zero flag reflects the produced result.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic [2:0]      func,
  output logic [SIZE-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    unique case (func)
      FUNC_ADD:    result = a + b;
      FUNC_SUB:    result = a - b;
      FUNC_AND:    result = a & b;
      FUNC_OR:     result = a | b;
      FUNC_NOR:    result = ~(a | b);
      FUNC_XOR:    result = a ^ b;
      FUNC_SLTU:   result = SIZE'(a < b);
      FUNC_PASS_B: result = b;
      default:     result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single ALU with exactly one
// operation in flight: accept in IDLE, compute in EXEC, hold result in RESP.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SIZE-1:0] req0_a,
  input  logic [SIZE-1:0] req0_b,
  input  logic [2:0]      req0_func,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SIZE-1:0] req1_a,
  input  logic [SIZE-1:0] req1_b,
  input  logic [2:0]      req1_func,

  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [SIZE-1:0] resp_out,
  output logic            resp_zero,
  output logic            busy
);

  state_t state;
  state_t next_state;

  logic            last_grant;
  logic            grant_id;
  logic            any_valid;
  logic            accept;

  logic [SIZE-1:0] op_a;
  logic [SIZE-1:0] op_b;
  logic [2:0]      op_func;
  logic            op_id;

  logic [SIZE-1:0] alu_result;
  logic            alu_zero;

  assign any_valid = req0_valid | req1_valid;
  assign grant_id  = pick_grant(req0_valid, req1_valid, last_grant);
  assign accept    = (state == ST_IDLE) && any_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (any_valid)  next_state = ST_EXEC;
      ST_EXEC:                 next_state = ST_RESP;
      ST_RESP: if (resp_ready) next_state = ST_IDLE;
      default:                 next_state = ST_IDLE;
    endcase
  end

  // Reset forces readies low even though the state register still shows IDLE.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req0_ready = accept && (grant_id == 1'b0);
        req1_ready = accept && (grant_id == 1'b1);
      end
      ST_EXEC: busy = 1'b1;
      ST_RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // Operands are captured only on the accept cycle, so later requester
  // activity cannot disturb the operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a       <= '0;
      op_b       <= '0;
      op_func    <= FUNC_ADD;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op_a       <= grant_id ? req1_a    : req0_a;
      op_b       <= grant_id ? req1_b    : req0_b;
      op_func    <= grant_id ? req1_func : req0_func;
      op_id      <= grant_id;
      last_grant <= grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_out  <= '0;
      resp_zero <= 1'b0;
      resp_id   <= 1'b0;
    end else if (state == ST_EXEC) begin
      resp_out  <= alu_result;
      resp_zero <= alu_zero;
      resp_id   <= op_id;
    end
  end

  alu_arbiter_alu #(
    .SIZE(SIZE)
  ) u_alu (
    .a     (op_a),
    .b     (op_b),
    .func  (op_func),
    .result(alu_result),
    .zero  (alu_zero)
  );

  a_ready_onehot: assert property (@(posedge clk) !(req0_ready && req1_ready));
  a_ready0_valid: assert property (@(posedge clk) req0_ready |-> req0_valid);
  a_ready1_valid: assert property (@(posedge clk) req1_ready |-> req1_valid);
  a_resp_stable:  assert property (@(posedge clk) disable iff (reset)
                    (resp_valid && !resp_ready) |=>
                    (resp_valid && $stable(resp_out) && $stable(resp_id) && $stable(resp_zero)));

endmodule
